// File: rtl/cv_weights_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cv_weights_loader
// Description : Fill stage for the conv weights buffer. Packs BEATS_PER_ROW
//               stream words into one row (beat 0 in the least significant
//               lane) and writes rows 0..N-1 to buffer port B. Raises
//               weights_ready once a complete load has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module cv_weights_loader #(
    parameter int WEIGHTS_IN_ROW    = 64,
    parameter int WEIGHT_ROW_LENGTH = WEIGHTS_IN_ROW * 8,
    parameter int IN_WIDTH          = 64,
    parameter int BEATS_PER_ROW     = WEIGHT_ROW_LENGTH / IN_WIDTH,
    parameter int ADR_WIDTH         = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic [ADR_WIDTH:0]           load_rows,
    input  logic [IN_WIDTH-1:0]          s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         wr_en,
    output logic [ADR_WIDTH-1:0]         wr_adr,
    output logic [WEIGHT_ROW_LENGTH-1:0] wr_data,
    output logic                         busy,
    output logic                         load_done,
    output logic                         weights_ready
);

    // Beat counter width; the pack register holds every lane except the last,
    // which is taken straight from s_data when the row completes.
    localparam int BEAT_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_W  = ADR_WIDTH + 1;
    localparam int PACK_W = WEIGHT_ROW_LENGTH - IN_WIDTH;

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  c_max_rows  = {1'b1, {ADR_WIDTH{1'b0}}};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]                   r_state;
    logic                         r_s_ready;
    logic                         r_weights_ready;
    logic [ROW_W-1:0]             r_rows;
    logic [ROW_W-1:0]             r_row_cnt;
    logic [BEAT_W-1:0]            r_beat_cnt;
    logic [PACK_W-1:0]            r_pack;
    logic                         r_wr_en;
    logic [ADR_WIDTH-1:0]         r_wr_adr;
    logic [WEIGHT_ROW_LENGTH-1:0] r_wr_data;

    logic [ROW_W-1:0] w_rows_req;
    logic             w_beat_fire;
    logic             w_row_end;
    logic             w_last_row;

    // Requests beyond the buffer depth are clamped so wr_adr never wraps.
    assign w_rows_req  = (load_rows > c_max_rows) ? c_max_rows : load_rows;
    // r_s_ready is only ever high in LOAD, so a fire implies LOAD.
    assign w_beat_fire = s_valid & r_s_ready;
    assign w_row_end   = w_beat_fire & (r_beat_cnt == c_last_beat);
    assign w_last_row  = ((r_row_cnt + ROW_W'(1)) == r_rows);

    assign s_ready       = r_s_ready;
    assign wr_en         = r_wr_en;
    assign wr_adr        = r_wr_adr;
    assign wr_data       = r_wr_data;
    assign weights_ready = r_weights_ready;
    assign busy          = (r_state != c_st_idle);
    assign load_done     = (r_state == c_st_done);

    // Load sequencing: state, stream handshake enable, counters and the ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_s_ready       <= 1'b0;
            r_weights_ready <= 1'b0;
            r_rows          <= '0;
            r_row_cnt       <= '0;
            r_beat_cnt      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (load_start) begin
                        r_rows          <= w_rows_req;
                        r_row_cnt       <= '0;
                        r_beat_cnt      <= '0;
                        r_weights_ready <= 1'b0;
                        if (w_rows_req == '0) begin
                            // A zero-row load still passes through FLUSH so its
                            // completion pulse lands two cycles after load_start.
                            r_state <= c_st_flush;
                        end else begin
                            r_state   <= c_st_load;
                            r_s_ready <= 1'b1;
                        end
                    end
                end
                c_st_load: begin
                    if (w_beat_fire) begin
                        if (r_beat_cnt == c_last_beat) begin
                            r_beat_cnt <= '0;
                            r_row_cnt  <= r_row_cnt + ROW_W'(1);
                            if (w_last_row) begin
                                r_state   <= c_st_flush;
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                c_st_flush: begin
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    r_weights_ready <= 1'b1;
                    r_state         <= c_st_idle;
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    // Row packing and the one-cycle buffer write issued on each row's final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pack    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_row_end) begin
                r_wr_data <= {s_data, r_pack};
                r_wr_adr  <= r_row_cnt[ADR_WIDTH-1:0];
                r_wr_en   <= 1'b1;
            end else if (w_beat_fire) begin
                for (int k = 0; k < BEATS_PER_ROW - 1; k++) begin
                    if (r_beat_cnt == BEAT_W'(k)) begin
                        r_pack[k*IN_WIDTH +: IN_WIDTH] <= s_data;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
